// File: rtl/mod_mul_arbiter_64b.sv
// Round-robin arbiter feeding a fixed-latency Barrett modular multiplier, with config load/drain FSM.
// Define MOD_MUL_ARB_FIXED_PRIO_EN to replace round-robin with lowest-index-wins priority.
`timescale 1ns/1ps
module mod_mul_arbiter_64b #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 64,
  parameter int LATENCY = 16
) (
  input  logic                       iClk,
  input  logic                       iRstN,
  input  logic [NUM_REQ-1:0]         iReqValid,
  output logic [NUM_REQ-1:0]         oReqReady,
  input  logic [NUM_REQ*WIDTH-1:0]   iReqData0,
  input  logic [NUM_REQ*WIDTH-1:0]   iReqData1,
  input  logic                       iCfgValid,
  output logic                       oCfgReady,
  input  logic [6:0]                 iCfgK,
  input  logic [2*WIDTH-1:0]         iCfgU,
  input  logic [WIDTH-1:0]           iCfgMod,
  output logic                       oMulEn,
  output logic                       oMulClr,
  output logic [6:0]                 oMulK,
  output logic [2*WIDTH-1:0]         oMulU,
  output logic [WIDTH-1:0]           oMulMod,
  output logic [WIDTH-1:0]           oMulData0,
  output logic [WIDTH-1:0]           oMulData1,
  input  logic [WIDTH-1:0]           iMulData,
  output logic [NUM_REQ-1:0]         oRspValid,
  output logic [WIDTH-1:0]           oRspData,
  output logic                       oBusy
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW  = $clog2(LATENCY + 2);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, CFG} state_e;
  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
  } tag_t;

  state_e               state_q, state_d;
  tag_t [LATENCY:0]     tag_q;
  tag_t                 new_tag;
  logic [CW-1:0]        infl_q, infl_d;
  logic                 cfg_ld_q;
  logic [6:0]           k_q;
  logic [2*WIDTH-1:0]   u_q;
  logic [WIDTH-1:0]     mod_q, d0_q, d1_q;

  logic                 grant_ok, acc, tag_exit, infl_zero, found;
  logic [NUM_REQ-1:0]   gnt;
  logic [IDW-1:0]       gid, cand, start;
  int                   idx;

  // Config request pre-empts arbitration in the same cycle.
  assign grant_ok  = (state_q == RUN) && cfg_ld_q && !iCfgValid;
  assign infl_zero = (infl_q == '0);
  assign tag_exit  = tag_q[LATENCY].vld;

`ifdef MOD_MUL_ARB_FIXED_PRIO_EN
  assign start = '0;
`else
  logic [IDW-1:0] ptr_q;
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN)   ptr_q <= '0;
    else if (acc) ptr_q <= (gid == IDW'(NUM_REQ - 1)) ? '0 : gid + 1'b1;
  end
  assign start = ptr_q;
`endif

  always_comb begin
    gnt   = '0;
    gid   = '0;
    found = 1'b0;
    idx   = 0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(start) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = IDW'(idx);
      if (grant_ok && !found && iReqValid[cand]) begin
        found     = 1'b1;
        gid       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

  assign oReqReady = gnt;
  assign acc       = found;
  assign new_tag   = {acc, gid};

  always_comb begin
    case ({acc, tag_exit})
      2'b10:   infl_d = infl_q + 1'b1;
      2'b01:   infl_d = infl_q - 1'b1;
      default: infl_d = infl_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (iCfgValid)                       state_d = CFG;
             else if (|iReqValid && cfg_ld_q)     state_d = RUN;
      RUN:   if (iCfgValid)                       state_d = DRAIN;
             else if (!(|iReqValid) && infl_zero) state_d = IDLE;
      DRAIN: if (infl_zero)                       state_d = CFG;
      CFG:                                        state_d = IDLE;
      default:                                    state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q  <= IDLE;
      tag_q    <= '0;
      infl_q   <= '0;
      cfg_ld_q <= 1'b0;
      k_q      <= '0;
      u_q      <= '0;
      mod_q    <= '0;
      d0_q     <= '0;
      d1_q     <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= {tag_q[LATENCY-1:0], new_tag};
      infl_q  <= infl_d;
      // CFG is only reachable with nothing in flight, so the multiplier never sees a mid-stream change.
      if (state_q == CFG) begin
        k_q      <= iCfgK;
        u_q      <= iCfgU;
        mod_q    <= iCfgMod;
        cfg_ld_q <= 1'b1;
      end
      if (acc) begin
        d0_q <= iReqData0[gid*WIDTH +: WIDTH];
        d1_q <= iReqData1[gid*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    oRspValid = '0;
    if (tag_q[LATENCY].vld) oRspValid[tag_q[LATENCY].id] = 1'b1;
  end

  assign oRspData  = tag_q[LATENCY].vld ? iMulData : '0;
  assign oCfgReady = (state_q == CFG);
  assign oMulClr   = (state_q == CFG);
  assign oMulEn    = !infl_zero || acc;
  assign oBusy     = (state_q != IDLE) || !infl_zero;
  assign oMulK     = k_q;
  assign oMulU     = u_q;
  assign oMulMod   = mod_q;
  assign oMulData0 = d0_q;
  assign oMulData1 = d1_q;
endmodule

// File: doc/mod_mul_arbiter_64b.md
MOD_MUL_ARBITER_64B -- requirements
Module: mod_mul_arbiter_64b

Interface
REQ-001 SHALL have parameters: NUM_REQ, 4, requester count | WIDTH, 64, operand width | LATENCY, 16, multiplier operand-to-result cycles.
REQ-002 SHALL have ports: iClk  in  1  single clock, rising edge; reset is asynchronous, active-low.
REQ-003 iRstN  in  1  asynchronous active-low reset.
REQ-004 iReqValid  in  NUM_REQ  per-requester operand valid | oReqReady  out  NUM_REQ  one-hot grant.
REQ-005 iReqData0, iReqData1  in  NUM_REQ*WIDTH  packed operands, requester i at bits [i*WIDTH +: WIDTH].
REQ-006 iCfgValid  in  1 | oCfgReady  out  1 | iCfgK  in  7 | iCfgU  in  2*WIDTH | iCfgMod  in  WIDTH  Barrett config.
REQ-007 oMulEn, oMulClr  out  1 | oMulK  out  7 | oMulU  out  2*WIDTH | oMulMod, oMulData0, oMulData1  out  WIDTH | iMulData  in  WIDTH  multiplier side.
REQ-008 oRspValid  out  NUM_REQ  one-hot result strobe | oRspData  out  WIDTH  result | oBusy  out  1  state != IDLE or in-flight != 0.

Function
REQ-009 FSM states IDLE, RUN, DRAIN, CFG; reset state IDLE.
REQ-010 Handshake: request i accepted on cycle where iReqValid[i] and oReqReady[i]; oReqReady combinational, at most one bit set, only in RUN with config loaded.
REQ-011 Arbitration round-robin: search starts at index after last granted; pointer updates only on accepted handshake.
REQ-012 Accepted operands registered onto oMulData0/1 at the accepting edge; tag {valid, id} enters a LATENCY+1 deep shift register.
REQ-013 Response: request accepted in cycle N -> oRspValid[id]=1 with oRspData=iMulData in cycle N+1+LATENCY; one response per cycle max; back-to-back accepts give back-to-back responses in order.
REQ-014 No backpressure on responses; requester must consume in that cycle.
REQ-015 In-flight counter (0..LATENCY+1): +1 on accept, -1 on tag exit, both same cycle -> unchanged.
REQ-016 IDLE->CFG when iCfgValid; else IDLE->RUN when any iReqValid and config loaded.
REQ-017 RUN->DRAIN when iCfgValid (cfg wins over requests that cycle; no grant); RUN->IDLE when no iReqValid and in-flight==0.
REQ-018 DRAIN: no grants; ->CFG when in-flight==0.
REQ-019 CFG (one cycle): oCfgReady=1, oMulK/oMulU/oMulMod load iCfgK/iCfgU/iCfgMod, oMulClr=1, config-loaded flag set; ->IDLE.
REQ-020 Requests before first config SHALL be held (ready 0), never dropped or granted.
REQ-021 oMulEn=1 when in-flight!=0 or accept this cycle, else 0; never deasserted with in-flight!=0.
REQ-022 Config outputs SHALL never change while in-flight!=0.

Reset
REQ-023 On iRstN low, immediately: state IDLE, all outputs 0, tags invalid, in-flight 0, pointer 0, config-loaded 0.
REQ-024 Reset mid-operation discards all in-flight tags; no oRspValid for them after release.
REQ-025 First state change SHALL occur at the first rising edge after iRstN deasserts.

Configuration
REQ-026 Macro MOD_MUL_ARB_FIXED_PRIO_EN: defined -> fixed priority, lowest index wins, pointer unused; undefined -> round-robin per REQ-011.

Verification
REQ-027 Cfg K=13, U=8736, Mod=7681; req0 operands 1467, 2489 accepted cycle N -> oRspValid=0001, oRspData=2888 at N+17.
REQ-028 All 4 requesters valid continuously for 8 cycles -> grants 0,1,2,3,0,1,2,3; responses same order, consecutive cycles, each equal (a*b)%Mod.
REQ-029 iCfgValid during RUN with 5 in flight -> no grants until all 5 responses out, then oCfgReady pulse and oMulClr for one cycle, new Mod used thereafter.
REQ-030 iReqValid=1111 before any config -> oReqReady=0000 indefinitely, oBusy=0.
REQ-031 Assert iRstN low with 3 in flight -> all outputs 0 immediately, no oRspValid in the following 20 cycles.
REQ-032 With MOD_MUL_ARB_FIXED_PRIO_EN, requesters 0 and 2 valid continuously -> requester 0 granted every cycle, 2 never.
